// File: rtl/udp_ip_pkg.sv
// Shared constants and state type for the UDP/IPv4 packet builder.
package udp_ip_pkg;

  localparam int IP_HDR_LEN      = 20;
  localparam int UDP_HDR_LEN     = 8;
  localparam int HDR_LEN         = 28;
  localparam int MIN_ETH_PAYLOAD = 46;
  localparam int BUF_DEPTH       = 2048;
  localparam int BUF_AW          = 11;

  localparam logic [7:0] IP_VER_IHL = 8'h45;
  localparam logic [7:0] PROTO_UDP  = 8'h11;

  typedef enum logic [1:0] {
    LOAD,
    CSUM,
    START,
    SEND
  } state_t;

endpackage

// File: rtl/udp_payload_buf.sv
// Payload store: 2048x8, synchronous write, combinational read.
module udp_payload_buf
  import udp_ip_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/udp_ip_pkt_gen.sv
// UDP/IPv4 packet builder feeding eth_send: buffers one payload,
// computes the IP header checksum, then serves header + payload bytes.
module udp_ip_pkt_gen
  import udp_ip_pkg::*;
#(
  parameter logic [31:0] SRC_IP      = 32'hC0A80002,
  parameter logic [31:0] DST_IP      = 32'hC0A80003,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd6102,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        tx_go,
  output logic [15:0] data_length,
  input  logic        fifo_rdreq,
  output logic [7:0]  fifo_rddata,
  input  logic        send_done,
  output logic        busy,
  output logic        drop_err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
  localparam logic [15:0] HDR_L   = 16'(HDR_LEN);
  localparam logic [15:0] UDP_L   = 16'(UDP_HDR_LEN);
  localparam logic [15:0] MIN_L   = 16'(MIN_ETH_PAYLOAD);

  state_t      state;
  logic [15:0] wptr;
  logic        overflow;
  logic [15:0] payload_len;
  logic [15:0] ip_total_len;
  logic [15:0] udp_len;
  logic [15:0] ip_id;
  logic [15:0] ip_checksum;
  logic [3:0]  csum_cnt;
  logic [19:0] csum_acc;
  logic [10:0] rd_idx;

  logic        in_range;
  logic        ovf_now;
  logic [15:0] len_now;
  logic        buf_we;
  logic [10:0] pay_idx;
  logic [7:0]  buf_rdata;
  logic [15:0] csum_word;
  logic [19:0] fold1;
  logic [15:0] fold2;
  logic [15:0] pay_end;
  logic [7:0]  hdr_byte;

  assign in_range = wptr < MAX_LEN;
  assign ovf_now  = overflow | ~in_range;
  assign len_now  = wptr + 16'd1;
  assign buf_we   = wr_en & (state == LOAD) & in_range;
  assign pay_idx  = rd_idx - 11'(HDR_LEN);
  assign pay_end  = payload_len + HDR_L;

  udp_payload_buf u_buf (
    .clk   (gmii_tx_clk),
    .we    (buf_we),
    .waddr (wptr[10:0]),
    .wdata (wr_data),
    .raddr (pay_idx),
    .rdata (buf_rdata)
  );

  // Header words in checksum order; word 5 is the checksum field itself.
  always_comb begin
    csum_word = '0;
    unique case (csum_cnt)
      4'd0:    csum_word = {IP_VER_IHL, 8'h00};
      4'd1:    csum_word = ip_total_len;
      4'd2:    csum_word = ip_id;
      4'd4:    csum_word = {TTL, PROTO_UDP};
      4'd6:    csum_word = SRC_IP[31:16];
      4'd7:    csum_word = SRC_IP[15:0];
      4'd8:    csum_word = DST_IP[31:16];
      4'd9:    csum_word = DST_IP[15:0];
      default: csum_word = '0;
    endcase
  end

  assign fold1 = {4'd0, csum_acc[15:0]} + {16'd0, csum_acc[19:16]};
  assign fold2 = fold1[15:0] + {12'd0, fold1[19:16]};

  always_comb begin
    hdr_byte = '0;
    unique case (rd_idx[4:0])
      5'd0:    hdr_byte = IP_VER_IHL;
      5'd2:    hdr_byte = ip_total_len[15:8];
      5'd3:    hdr_byte = ip_total_len[7:0];
      5'd4:    hdr_byte = ip_id[15:8];
      5'd5:    hdr_byte = ip_id[7:0];
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = PROTO_UDP;
      5'd10:   hdr_byte = ip_checksum[15:8];
      5'd11:   hdr_byte = ip_checksum[7:0];
      5'd12:   hdr_byte = SRC_IP[31:24];
      5'd13:   hdr_byte = SRC_IP[23:16];
      5'd14:   hdr_byte = SRC_IP[15:8];
      5'd15:   hdr_byte = SRC_IP[7:0];
      5'd16:   hdr_byte = DST_IP[31:24];
      5'd17:   hdr_byte = DST_IP[23:16];
      5'd18:   hdr_byte = DST_IP[15:8];
      5'd19:   hdr_byte = DST_IP[7:0];
      5'd20:   hdr_byte = SRC_PORT[15:8];
      5'd21:   hdr_byte = SRC_PORT[7:0];
      5'd22:   hdr_byte = DST_PORT[15:8];
      5'd23:   hdr_byte = DST_PORT[7:0];
      5'd24:   hdr_byte = udp_len[15:8];
      5'd25:   hdr_byte = udp_len[7:0];
      default: hdr_byte = '0;
    endcase
  end

  always_comb begin
    fifo_rddata = '0;
    if (state == SEND) begin
      if (rd_idx < 11'(HDR_LEN)) fifo_rddata = hdr_byte;
      else if ({5'd0, rd_idx} < pay_end) fifo_rddata = buf_rdata;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      wr_ready     <= 1'b1;
      tx_go        <= 1'b0;
      busy         <= 1'b0;
      drop_err     <= 1'b0;
      data_length  <= '0;
      wptr         <= '0;
      overflow     <= 1'b0;
      payload_len  <= '0;
      ip_total_len <= '0;
      udp_len      <= '0;
      ip_id        <= '0;
      ip_checksum  <= '0;
      csum_cnt     <= '0;
      csum_acc     <= '0;
      rd_idx       <= '0;
    end else begin
      tx_go    <= 1'b0;
      drop_err <= 1'b0;
      unique case (state)
        LOAD: begin
          if (wr_en) begin
            if (wptr != 16'hFFFF) wptr <= len_now;
            if (!in_range) overflow <= 1'b1;
            if (wr_last) begin
              if (ovf_now) begin
                drop_err <= 1'b1;
                wptr     <= '0;
                overflow <= 1'b0;
              end else begin
                payload_len  <= len_now;
                ip_total_len <= len_now + HDR_L;
                udp_len      <= len_now + UDP_L;
                csum_cnt     <= '0;
                csum_acc     <= '0;
                wr_ready     <= 1'b0;
                busy         <= 1'b1;
                state        <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          csum_cnt <= csum_cnt + 4'd1;
          if (csum_cnt == 4'd10) begin
            ip_checksum <= ~fold2;
            tx_go       <= 1'b1;
            data_length <= (ip_total_len > MIN_L) ? ip_total_len : MIN_L;
            rd_idx      <= '0;
            state       <= START;
          end else begin
            csum_acc <= csum_acc + {4'd0, csum_word};
          end
        end
        START: begin
          rd_idx <= '0;
          state  <= SEND;
        end
        SEND: begin
          if (send_done) begin
            ip_id    <= ip_id + 16'd1;
            wptr     <= '0;
            overflow <= 1'b0;
            rd_idx   <= '0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= LOAD;
          end else if (fifo_rdreq && rd_idx != 11'h7FF) begin
            rd_idx <= rd_idx + 11'd1;
          end
        end
      endcase
    end
  end

endmodule
